// File: rtl/int_ctrl.sv
// int_ctrl: priority interrupt controller with a gateway, claim/complete handshake and registered arbitration.
// Define INT_CTRL_EDGE_EN to make register 0x24 select edge-triggered sources; otherwise every source is level-sensitive.
module int_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_we_i,
    input  logic [5:0]         cfg_addr_i,
    input  logic [31:0]        cfg_data_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic               claim_i,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               complete_i,
    input  logic [ID_W-1:0]    complete_id_i,
    output logic               int_o
);
    localparam logic [5:0] ADDR_ENABLE    = 6'h20;
    localparam logic [5:0] ADDR_PENDING   = 6'h21;
    localparam logic [5:0] ADDR_THRESHOLD = 6'h22;
    localparam logic [5:0] ADDR_INSERVICE = 6'h23;
    localparam logic [5:0] ADDR_EDGE      = 6'h24;

    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [PRIO_W-1:0]  threshold;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] inservice;
    logic [ID_W-1:0]    best_id;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] complete_mask;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] inservice_nxt;
    logic [ID_W-1:0]    best_nxt;
    logic [PRIO_W-1:0]  best_prio;
    logic [31:0]        rdata_nxt;
    logic               unused_cfg;

    assign unused_cfg = ^cfg_data_i;

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] edge_mask;
    logic [NUM_SRC-1:0] src_q;
    assign req = (src_i & ~src_q & edge_mask) | (src_i & ~edge_mask);
`else
    assign req = src_i;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            claim_mask[k]    = claim_i && (best_id == ID_W'(k + 1));
            complete_mask[k] = complete_i && (complete_id_i == ID_W'(k + 1));
        end
    end

    // A request meeting a pending or in-service source is dropped; a claimed source leaves arbitration at the claim edge.
    assign pending_nxt   = (pending | (req & ~inservice)) & ~claim_mask;
    assign inservice_nxt = (inservice | claim_mask) & ~complete_mask;

    // NOTE: blocking assignments in combinational logic let the loop carry the running best forward within one evaluation.
    always_comb begin
        best_nxt  = '0;
        best_prio = threshold;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pending[k] && !claim_mask[k] && enable[k] && (prio[k] > best_prio)) begin
                best_nxt  = ID_W'(k + 1);
                best_prio = prio[k];
            end
        end
    end

    always_comb begin
        rdata_nxt = '0;
        case (cfg_addr_i)
            ADDR_ENABLE:    rdata_nxt = 32'(enable);
            ADDR_PENDING:   rdata_nxt = 32'(pending);
            ADDR_THRESHOLD: rdata_nxt = 32'(threshold);
            ADDR_INSERVICE: rdata_nxt = 32'(inservice);
`ifdef INT_CTRL_EDGE_EN
            ADDR_EDGE:      rdata_nxt = 32'(edge_mask);
`endif
            default: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (cfg_addr_i == 6'(k + 1)) rdata_nxt = 32'(prio[k]);
                end
            end
        endcase
    end

    // NOTE: the priority file is a handful of flops, not a RAM, so it is reset along with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SRC; k++) prio[k] <= '0;
            enable      <= '0;
            threshold   <= '0;
            pending     <= '0;
            inservice   <= '0;
            best_id     <= '0;
            claim_id_o  <= '0;
            int_o       <= 1'b0;
            cfg_rdata_o <= '0;
`ifdef INT_CTRL_EDGE_EN
            edge_mask   <= '0;
            src_q       <= '0;
`endif
        end else begin
            if (cfg_we_i) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (cfg_addr_i == 6'(k + 1)) prio[k] <= cfg_data_i[PRIO_W-1:0];
                end
                if (cfg_addr_i == ADDR_ENABLE)    enable    <= cfg_data_i[NUM_SRC-1:0];
                if (cfg_addr_i == ADDR_THRESHOLD) threshold <= cfg_data_i[PRIO_W-1:0];
`ifdef INT_CTRL_EDGE_EN
                if (cfg_addr_i == ADDR_EDGE)      edge_mask <= cfg_data_i[NUM_SRC-1:0];
`endif
            end
            pending     <= pending_nxt;
            inservice   <= inservice_nxt;
            best_id     <= best_nxt;
            int_o       <= (best_nxt != '0);
            cfg_rdata_o <= rdata_nxt;
            if (claim_i) claim_id_o <= best_id;
`ifdef INT_CTRL_EDGE_EN
            src_q       <= src_i;
`endif
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic against a behavioural model.
// A scoreboard queue carries the expected int_o, claim_id_o and cfg_rdata_o for every clock edge.
module tb_int_ctrl;
    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  src = '0;
    logic          cfg_we = 1'b0;
    logic [5:0]    cfg_addr = '0;
    logic [31:0]   cfg_data = '0;
    logic [31:0]   cfg_rdata;
    logic          claim = 1'b0;
    logic [IW-1:0] claim_id;
    logic          complete = 1'b0;
    logic [IW-1:0] complete_id = '0;
    logic          int_o;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_SRC(N), .PRIO_W(PW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .src_i(src),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_rdata_o(cfg_rdata),
        .claim_i(claim), .claim_id_o(claim_id),
        .complete_i(complete), .complete_id_i(complete_id),
        .int_o(int_o)
    );

    typedef struct {
        string         tag;
        logic          int_v;
        logic [IW-1:0] claim;
        logic [31:0]   rd;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    // Reference model state, indexed by source ID.
    bit m_pend[1:N];
    bit m_ins[1:N];
    bit m_en[1:N];
    bit m_edge[1:N];
    bit m_prev[1:N];
    int m_prio[1:N];
    int m_thr;
    int m_best;
    int m_claim;
    bit m_int;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] v;
        v = '0;
        if (a >= 1 && a <= N) v = 32'(m_prio[a]);
        for (int id = 1; id <= N; id++) begin
            if (a == 32) v[id-1] = m_en[id];
            if (a == 33) v[id-1] = m_pend[id];
            if (a == 35) v[id-1] = m_ins[id];
`ifdef INT_CTRL_EDGE_EN
            if (a == 36) v[id-1] = m_edge[id];
`endif
        end
        if (a == 34) v = 32'(m_thr);
        return v;
    endfunction

    // Highest eligible priority first, then the lowest ID carrying it.
    function automatic int m_arb(input int skip);
        int top;
        top = 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && id != skip && m_en[id] && m_prio[id] > m_thr && m_prio[id] > top)
                top = m_prio[id];
        if (top == 0) return 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && id != skip && m_en[id] && m_prio[id] == top) return id;
        return 0;
    endfunction

    task automatic model_edge();
        int claimed;
        int nb;
        bit req;
        bit np[1:N];
        bit ni[1:N];
        if (rst) begin
            for (int id = 1; id <= N; id++) begin
                m_pend[id] = 0; m_ins[id] = 0; m_en[id] = 0;
                m_edge[id] = 0; m_prev[id] = 0; m_prio[id] = 0;
            end
            m_thr = 0; m_best = 0; m_claim = 0; m_int = 0; m_rd = '0;
            return;
        end
        m_rd    = m_read(int'(cfg_addr));
        claimed = claim ? m_best : 0;
        if (claim) m_claim = m_best;
        nb = m_arb(claimed);
        for (int id = 1; id <= N; id++) begin
            req = src[id-1];
`ifdef INT_CTRL_EDGE_EN
            if (m_edge[id]) req = src[id-1] && !m_prev[id];
`endif
            np[id] = (m_pend[id] || (req && !m_ins[id])) && (id != claimed);
            ni[id] = (m_ins[id] || id == claimed) && !(complete && int'(complete_id) == id);
        end
        for (int id = 1; id <= N; id++) begin
            m_pend[id] = np[id];
            m_ins[id]  = ni[id];
            m_prev[id] = src[id-1];
        end
        if (cfg_we) begin
            if (int'(cfg_addr) >= 1 && int'(cfg_addr) <= N) m_prio[int'(cfg_addr)] = int'(cfg_data[PW-1:0]);
            if (cfg_addr == 6'h22) m_thr = int'(cfg_data[PW-1:0]);
            for (int id = 1; id <= N; id++) begin
                if (cfg_addr == 6'h20) m_en[id] = cfg_data[id-1];
`ifdef INT_CTRL_EDGE_EN
                if (cfg_addr == 6'h24) m_edge[id] = cfg_data[id-1];
`endif
            end
        end
        m_best = nb;
        m_int  = (nb != 0);
    endtask

    // One clock edge: advance the model and queue what the DUT must show after this edge.
    task automatic step(input int want_claim = -1);
        exp_t e;
        @(posedge clk);
        model_edge();
        e.tag   = phase;
        e.int_v = m_int;
        e.claim = IW'(m_claim);
        e.rd    = m_rd;
        if (want_claim >= 0 && claim) e.claim = IW'(want_claim);
        sb.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "/int_o"}, 32'(int_o), 32'(e.int_v));
                check({e.tag, "/claim_id_o"}, 32'(claim_id), 32'(e.claim));
                check({e.tag, "/cfg_rdata_o"}, cfg_rdata, e.rd);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = 32'(d);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_claim(input int want);
        claim = 1'b1;
        step(want);
        claim = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete = 1'b1; complete_id = IW'(id);
        step();
        complete = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; claim = 1'b0; complete = 1'b0; cfg_we = 1'b0; src = '0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        do_reset();

        phase = "priority";
        wr(3, 5); wr(32, 8'h04); wr(34, 0);
        cfg_addr = 6'h21;
        src = 8'h04; step(); src = '0;
        idle(2);
        do_claim(3);
        idle(2);
        do_complete(3);
        idle(1);

        phase = "tie";
        do_reset();
        wr(2, 4); wr(5, 4); wr(32, 8'hFF);
        cfg_addr = 6'h21;
        src = 8'h12; step(); src = '0;
        idle(2);
        do_claim(2);
        idle(1);
        do_claim(5);
        cfg_addr = 6'h23;
        idle(2);

        phase = "threshold";
        do_reset();
        wr(1, 2); wr(32, 8'h01); wr(34, 2);
        src = 8'h01;
        idle(4);
        wr(34, 1);
        idle(3);
        src = '0;
        do_claim(1);
        do_complete(1);
        idle(2);

        phase = "level";
        do_reset();
        wr(4, 3); wr(32, 8'h08);
        cfg_addr = 6'h21;
        src = 8'h08;
        idle(3);
        do_claim(4);
        idle(3);
        do_complete(4);
        idle(3);
        src = '0;
        do_claim(4);
        do_complete(4);
        idle(1);

        phase = "bounds";
        do_reset();
        cfg_addr = 6'h21;
        do_claim(0);
        idle(1);
        wr(2, 3); wr(1, 1); wr(32, 8'hFF);
        src = 8'h02; step(); src = '0;
        idle(2);
        do_claim(2);
        src = 8'h01; step(); src = '0;
        cfg_addr = 6'h23;
        idle(2);
        do_complete(7);
        do_complete(0);
        do_complete(31);
        cfg_addr = 6'h21;
        idle(1);
        do_reset();
        idle(1);
        cfg_addr = 6'h23;
        idle(1);
        do_complete(2);
        idle(1);

`ifdef INT_CTRL_EDGE_EN
        phase = "edge";
        do_reset();
        wr(1, 1); wr(32, 8'h01); wr(36, 8'h01);
        cfg_addr = 6'h21;
        src = 8'h01;
        idle(3);
        do_claim(1);
        idle(2);
        do_complete(1);
        idle(4);
        src = '0; idle(1);
        src = 8'h01; idle(3);
        do_claim(1);
        do_complete(1);
        idle(1);
`endif

        phase = "random";
        do_reset();
        for (int id = 1; id <= N; id++) wr(id, int'($urandom_range(0, 7)));
        wr(32, int'($urandom_range(0, 255)));
        wr(34, int'($urandom_range(0, 2)));
`ifdef INT_CTRL_EDGE_EN
        wr(36, int'($urandom_range(0, 255)));
`endif
        for (int i = 0; i < 400; i++) begin
            src         = N'($urandom);
            claim       = ($urandom_range(0, 3) == 0);
            complete    = ($urandom_range(0, 2) == 0);
            complete_id = IW'($urandom_range(0, 9));
            cfg_we      = ($urandom_range(0, 9) == 0);
            cfg_addr    = 6'($urandom_range(0, 39));
            cfg_data    = $urandom;
            step();
        end
        claim = 1'b0; complete = 1'b0; cfg_we = 1'b0; src = '0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset; ports are named clk and rst, and no other clock or reset SHALL exist.
REQ-002 The block SHALL provide these parameters, one per line (name, default, meaning):
- NUM_SRC, 8, number of interrupt sources (legal range 2..31).
- PRIO_W, 3, priority field width in bits.
- ID_W, 5, source ID width; ID 0 means "no interrupt".
REQ-003 The block SHALL provide these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- src_i  in  NUM_SRC  raw source requests; bit k is source ID k+1.
- cfg_we_i  in  1  configuration write strobe.
- cfg_addr_i  in  6  configuration register address.
- cfg_data_i  in  32  configuration write data.
- cfg_rdata_o  out  32  registered read data for the cfg_addr_i presented in the previous cycle.
- claim_i  in  1  single-cycle claim pulse.
- claim_id_o  out  ID_W  ID returned by the most recent claim.
- complete_i  in  1  single-cycle completion pulse.
- complete_id_i  in  ID_W  ID being completed.
- int_o  out  1  interrupt request to the core's int_i.

Function
REQ-004 The register map SHALL be:
- 0x01..NUM_SRC: priority of that source ID, in bits [PRIO_W-1:0].
- 0x20: enable mask, bit k for ID k+1.
- 0x21: pending, read-only.
- 0x22: threshold, in bits [PRIO_W-1:0].
- 0x23: in-service, read-only.
- 0x24: edge-mode mask (see REQ-017).
- All other addresses SHALL read 0 and ignore writes.
REQ-005 Gateway: pending[k] SHALL set at a clock edge when src_i[k]=1, pending[k]=0 and inservice[k]=0; otherwise the request SHALL be ignored.
REQ-006 A source is eligible when pending=1, enable=1 and priority > threshold; priority 0 SHALL never be eligible.
REQ-007 Arbitration SHALL register best_id as the eligible ID with the highest priority; ties SHALL go to the lowest ID; best_id SHALL be 0 when no source is eligible.
REQ-008 int_o SHALL be registered as (best_id != 0). If src_i[k] is high before edge N, pending SHALL be 1 after edge N and int_o SHALL be 1 after edge N+1.
REQ-009 On claim_i=1 at an edge:
- claim_id_o SHALL load the registered best_id.
- pending[best_id] SHALL clear and inservice[best_id] SHALL set.
- If best_id=0, claim_id_o SHALL load 0 and no other state SHALL change.
- claim_id_o SHALL hold its value until the next claim.
REQ-010 On complete_i=1 with inservice[complete_id_i]=1, that in-service bit SHALL clear at the edge. Completion of ID 0, an out-of-range ID, or an ID not in service SHALL be ignored.
REQ-011 Simultaneous claim and complete SHALL both take effect in the same edge.
REQ-012 A source request arriving in the same cycle its ID is claimed SHALL be dropped; a level source re-pends after completion if it is still high.
REQ-013 A configuration write coinciding with a claim SHALL take effect, but the claim SHALL use the pre-write best_id; arbitration SHALL reflect the new configuration one edge later.
REQ-014 Lowering enable, priority or raising threshold SHALL NOT clear pending; it SHALL only remove eligibility.

Reset
REQ-015 While rst=1 at an edge, the following SHALL become 0: all priorities, enable, threshold, edge mask, pending, inservice, best_id, claim_id_o, int_o and cfg_rdata_o.
REQ-016 rst asserted mid-handshake SHALL discard all in-service state; a later complete_i for a pre-reset ID SHALL be ignored.

Configuration
REQ-017 When macro INT_CTRL_EDGE_EN is defined:
- Register 0x24 SHALL be writable.
- A source with its edge-mask bit set SHALL pend on a 0-to-1 transition of src_i, detected against a registered copy reset to 0.
- An edge arriving while the source is pending or in service SHALL be lost.
REQ-018 When INT_CTRL_EDGE_EN is undefined, all sources SHALL be level-sensitive, 0x24 SHALL read 0, and writes to 0x24 SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Priority: prio[3]=5, enable=0x04, threshold=0, pulse src_i[2] high → int_o=1 two edges later; claim → claim_id_o=3, int_o=0 next edge.
- Tie: prio[2]=prio[5]=4, src_i=0x12, enable=0xFF → claim returns 2, a second claim returns 5.
- Threshold: prio[1]=2, threshold=2, src 1 high → int_o stays 0; write threshold=1 → int_o=1 two edges after the write.
- Level re-pend: claim ID 4 with src_i[3] held high → no re-pend while in service; complete_id_i=4 → pending[3]=1 next edge, int_o=1 the edge after.
- Boundaries: claim with nothing pending → claim_id_o=0 and no state change; complete_id_i=7 when not in service → no change; rst mid-service → pending=inservice=0.
- With INT_CTRL_EDGE_EN defined: edge mask 0x01, src_i[0] held high → exactly one claim of ID 1; after completion no re-pend until src_i[0] falls and rises again.
